// File: rtl/bin_to_bcd_pkg.sv
// Shared types and constants for the sequential double-dabble converter.
// min_digits() gives the smallest digit count whose decimal range exceeds 2**w.
package bin_to_bcd_pkg;

    typedef enum logic [1:0] {IDLE, CONV, DONE} conv_state_t;

    localparam int         BCD_DIGIT_W    = 4;
    localparam logic [3:0] BCD_ADJ_THRESH = 4'd4;
    localparam logic [3:0] BCD_ADJ_VAL    = 4'd3;

    function automatic int min_digits(input int w);
        longint unsigned p;
        longint unsigned lim;
        int              d;
        p   = 1;
        lim = longint'(1) << w;
        d   = 0;
        while (p <= lim) begin
            p = p * 10;
            d = d + 1;
        end
        return d;
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Combinational add-3 correction: every BCD digit above 4 gets +3 (mod 16).
// Zero latency, no flow control.
module bcd_digit_adjust
    import bin_to_bcd_pkg::*;
#(
    parameter int N_DIGITS = 3
) (
    input  logic [BCD_DIGIT_W*N_DIGITS-1:0] bcd_raw,
    output logic [BCD_DIGIT_W*N_DIGITS-1:0] bcd_adj
);

    always_comb begin
        bcd_adj = bcd_raw;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (bcd_raw[k*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_ADJ_THRESH) begin
                bcd_adj[k*BCD_DIGIT_W +: BCD_DIGIT_W] =
                    bcd_raw[k*BCD_DIGIT_W +: BCD_DIGIT_W] + BCD_ADJ_VAL;
            end
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD (one bit per clock), optional sign+magnitude; result W_BIN+1 edges after accept.
// No queueing: i_start is ignored while o_busy, accepted in IDLE or in the DONE cycle.
module bin_to_bcd_seq
    import bin_to_bcd_pkg::*;
#(
    parameter int W_BIN    = 8,
    parameter int N_DIGITS = 3
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_start,
    input  logic                            i_signed,
    input  logic [W_BIN-1:0]                i_bin,
    output logic                            o_busy,
    output logic                            o_done,
    output logic                            o_sign,
    output logic [BCD_DIGIT_W*N_DIGITS-1:0] o_bcd
);

    localparam int                BCD_W    = BCD_DIGIT_W * N_DIGITS;
    localparam int                CNT_W    = $clog2(W_BIN);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(W_BIN - 1);

    if (W_BIN < 2) begin : g_bad_width
        $error("bin_to_bcd_seq: W_BIN must be at least 2");
    end
    if (N_DIGITS < min_digits(W_BIN)) begin : g_bad_digits
        $error("bin_to_bcd_seq: N_DIGITS too small for W_BIN");
    end

    conv_state_t      state;
    logic [BCD_W-1:0] bcd_acc;
    logic [W_BIN-1:0] bin_sr;
    logic [CNT_W-1:0] cnt;
    logic             sign_pend;

    logic [BCD_W-1:0] bcd_adj;
    logic [BCD_W-1:0] bcd_next;
    logic [W_BIN-1:0] bin_next;
    logic [W_BIN-1:0] mag;
    logic             neg_in;

    bcd_digit_adjust #(.N_DIGITS(N_DIGITS)) u_adjust (
        .bcd_raw (bcd_acc),
        .bcd_adj (bcd_adj)
    );

    // Correction and the 1-bit left shift of {bcd, bin} land in the same edge.
    assign bcd_next = {bcd_adj[BCD_W-2:0], bin_sr[W_BIN-1]};
    assign bin_next = {bin_sr[W_BIN-2:0], 1'b0};

    // The most-negative operand negates to itself, which is the right unsigned magnitude.
    assign neg_in = i_signed & i_bin[W_BIN-1];
    assign mag    = neg_in ? (~i_bin + W_BIN'(1)) : i_bin;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            bcd_acc   <= '0;
            bin_sr    <= '0;
            cnt       <= '0;
            sign_pend <= 1'b0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_sign    <= 1'b0;
            o_bcd     <= '0;
        end else begin
            case (state)
                CONV: begin
                    bcd_acc <= bcd_next;
                    bin_sr  <= bin_next;
                    cnt     <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        state  <= DONE;
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                        o_bcd  <= bcd_next;
                        o_sign <= sign_pend;
                    end
                end
                default: begin
                    o_done <= 1'b0;
                    if (i_start) begin
                        state     <= CONV;
                        o_busy    <= 1'b1;
                        bcd_acc   <= '0;
                        bin_sr    <= mag;
                        cnt       <= '0;
                        sign_pend <= neg_in;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule
